// File: rtl/cpu64_l3_repl_ctrl.sv
// L3 miss-replacement sequencer: picks a victim through the shared 16-way PLRU, writes it back
// if dirty, issues the line fill, then commits tag + PLRU touch. Hit-path touches share the port.
module cpu64_l3_repl_ctrl #(
  parameter int unsigned SET_W = 11,
  parameter int unsigned TAG_W = 28
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [SET_W-1:0] req_set_i,
  input  logic [TAG_W-1:0] req_tag_i,
  input  logic             touch_valid_i,
  output logic             touch_ready_o,
  input  logic [SET_W-1:0] touch_set_i,
  input  logic [3:0]       touch_way_i,
  output logic             meta_rd_o,
  output logic [SET_W-1:0] meta_set_o,
  input  logic [15:0]      meta_valid_i,
  input  logic [15:0]      meta_dirty_i,
  output logic             meta_wr_o,
  output logic [SET_W-1:0] plru_set_o,
  output logic             plru_access_o,
  output logic [3:0]       plru_way_o,
  output logic [15:0]      plru_valid_o,
  input  logic [3:0]       plru_victim_i,
  output logic             wb_valid_o,
  input  logic             wb_ready_i,
  output logic             fill_valid_o,
  input  logic             fill_ready_i,
  input  logic             fill_done_i,
  output logic [SET_W-1:0] fill_set_o,
  output logic [3:0]       fill_way_o,
  output logic [TAG_W-1:0] fill_tag_o,
  output logic             done_o,
  output logic             busy_o
);

  // state    | meaning
  // IDLE     | ready for a miss
  // RD       | metadata read strobe for the latched set
  // SEL      | PLRU owns the port, victim and dirty flag are latched
  // WB       | dirty victim writeback handshake
  // FILL     | line fill request handshake
  // FWAIT    | waiting for the fill engine to finish writing data
  // UPD      | tag write + PLRU touch commit, done pulse
  typedef enum logic [2:0] {
    ST_IDLE, ST_RD, ST_SEL, ST_WB, ST_FILL, ST_FWAIT, ST_UPD
  } state_e;

  state_e             state_q, state_d;
  logic [SET_W-1:0]   set_q;
  logic [TAG_W-1:0]   tag_q;
  logic [3:0]         victim_q;
  logic               dirty_q;
  logic               sel_dirty;

  assign sel_dirty  = meta_valid_i[plru_victim_i] & meta_dirty_i[plru_victim_i];
  assign fill_set_o = set_q;
  assign fill_way_o = victim_q;
  assign fill_tag_o = tag_q;
  assign busy_o     = (state_q != ST_IDLE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      set_q    <= '0;
      tag_q    <= '0;
      victim_q <= '0;
      dirty_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (req_valid_i && req_ready_o) begin
        set_q <= req_set_i;
        tag_q <= req_tag_i;
      end
      if (state_q == ST_SEL) begin
        victim_q <= plru_victim_i;
        dirty_q  <= sel_dirty;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    req_ready_o   = 1'b0;
    meta_rd_o     = 1'b0;
    meta_set_o    = set_q;
    meta_wr_o     = 1'b0;
    plru_access_o = 1'b0;
    plru_set_o    = set_q;
    plru_way_o    = victim_q;
    plru_valid_o  = 16'hFFFF;
    wb_valid_o    = 1'b0;
    fill_valid_o  = 1'b0;
    done_o        = 1'b0;
    touch_ready_o = (state_q != ST_SEL) && (state_q != ST_UPD);

    // Hit touches pass straight through whenever the sequencer is not using the port.
    if (touch_valid_i && touch_ready_o) begin
      plru_access_o = 1'b1;
      plru_set_o    = touch_set_i;
      plru_way_o    = touch_way_i;
    end

    unique case (state_q)
      ST_IDLE: begin
        req_ready_o = 1'b1;
        meta_set_o  = '0;
        if (req_valid_i) state_d = ST_RD;
      end
      ST_RD: begin
        meta_rd_o = 1'b1;
        state_d   = ST_SEL;
      end
      ST_SEL: begin
        plru_valid_o = meta_valid_i;
        state_d      = sel_dirty ? ST_WB : ST_FILL;
      end
      ST_WB: begin
        wb_valid_o = dirty_q;
        if (wb_ready_i) state_d = ST_FILL;
      end
      ST_FILL: begin
        fill_valid_o = 1'b1;
        if (fill_ready_i) state_d = ST_FWAIT;
      end
      ST_FWAIT: begin
        if (fill_done_i) state_d = ST_UPD;
      end
      ST_UPD: begin
        meta_wr_o     = 1'b1;
        plru_access_o = 1'b1;
        plru_set_o    = set_q;
        plru_way_o    = victim_q;
        done_o        = 1'b1;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
